conv_param_fetch: RTL and testbench
===================================

Name: conv_param_fetch

Overview:
Read-side sequencer for the conv weight and bias parameter RAMs. On a start request for one filter, it issues 9 weight reads and 1 bias read. It absorbs the RAMs' 1-cycle registered read latency and assembles one parameter bundle (9 signed int8 weights plus one signed 32-bit bias). The bundle goes to the conv compute engine over a valid/ready handshake. The block sits between the parameter RAMs, which are filled by the UART loader, and the conv MAC datapath.

Parameters:
NUM_FILTERS, 4, number of filters stored; legal filter_idx range is 0..NUM_FILTERS-1
KERNEL_TAPS, 9, weights per filter (3x3); weight RAM base address = filter_idx*KERNEL_TAPS

Ports:
clk  in  1  system clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  fetch request, sampled on rising edge
filter_idx  in  3  filter to fetch, sampled together with start
w_rd_addr  out  6  weight RAM read address (registered)
w_rd_data  in  8  weight RAM read data, valid 1 cycle after the address edge
b_rd_addr  out  4  bias RAM read address (registered), value {1'b0, filter_idx}
b_rd_data  in  32  bias RAM read data, valid 1 cycle after the address edge
busy  out  1  high from start acceptance until bundle handshake completes
params_valid  out  1  bundle valid
params_ready  in  1  consumer accepts bundle
weights  out  72  weights[8k+:8] = tap k, k = row*3+col, signed int8, unmodified
bias  out  32  signed bias, unmodified
filter_out  out  3  filter index the bundle belongs to
err  out  1  one-cycle pulse on a rejected start

Behaviour:
- Reset (async, rst_n low): state=IDLE; w_rd_addr=0, b_rd_addr=0, busy=0, params_valid=0, weights=0, bias=0, filter_out=0, err=0. Reset mid-fetch or mid-hold aborts with no bundle delivered.
- FSM states: IDLE, FETCH, DRAIN, HOLD.
- IDLE: on start with filter_idx<NUM_FILTERS, the block does the following at the same edge:
  - latches filter_idx into filter_out and sets busy=1;
  - sets w_rd_addr=filter_idx*9 and tap counter=0;
  - goes to FETCH.
- Rejected start: filter_idx>=NUM_FILTERS gives err=1 for exactly one cycle, and the block stays IDLE.
- Start edge is E0. At edge Ek (k=1..8), w_rd_addr = base+k. At edge E(k+1) (k=0..8), w_rd_data is captured into weights[8k+:8].
- At E9, b_rd_addr={1'b0,filter} and the state goes to DRAIN. At E10, weight tap 8 is captured. At E11, b_rd_data is captured into bias, params_valid=1, and the state goes to HOLD.
- Latency: params_valid is high after exactly 11 rising edges following the start edge, with params_ready irrelevant until HOLD.
- HOLD: weights, bias and filter_out are held stable while params_valid=1 and params_ready=0.
- Transfer occurs on an edge where params_valid&&params_ready. At that edge, params_valid=0, and:
  - if start is also high with a legal index, the next fetch begins at the same edge (back-to-back; busy stays 1);
  - otherwise busy=0 and the state goes to IDLE.
- Start during FETCH or DRAIN, or during HOLD without a transfer, is ignored: no err and no effect.
- params_ready outside HOLD has no effect.
- Address arithmetic: base = filter_idx*9 computed at 6-bit width. The maximum address is 35, so there is no wrap. The tap counter saturates at 8.
- The block drives no RAM write ports. Loader writes during busy=1 are a system-level violation, and bundle contents are undefined in that case.
- Outputs change only on clk edges, except the asynchronous reset clear.

Test Plan:
- Preload weight RAM[i]=i+1 (i=0..35) and bias RAM[f]=32'h100+f. Start with filter_idx=2 → params_valid after 11 edges; weights taps 0..8 = 19..27 (tap0 in bits 7:0); bias=32'h102; filter_out=2; w_rd_addr sequence is 18..26.
- Hold params_ready low for 5 cycles after valid → weights, bias and params_valid stay stable. Raise ready → valid drops the next edge, busy=0.
- Start filter 0 and hold params_ready=1 with start high and filter_idx=3 in the transfer cycle → the second bundle (taps 28..36, bias 32'h103) is valid 11 edges later, and busy never drops.
- Start with filter_idx=5 → err high for one cycle, busy stays 0, no RAM address change. A start pulse during FETCH is ignored and the bundle is still correct.
- Set tap0=8'h80, tap8=8'h7F, bias=32'hFFFF_FF85 for filter 1 → the bundle shows the exact bit patterns, with no sign manipulation.
- Assert rst_n low at edge E5 of a fetch → all outputs 0 immediately. After release, a new start on filter 3 completes normally.

Source files
------------

// File: rtl/conv_param_fetch.sv
// conv_param_fetch: reads one filter's 9 int8 weights and its 32-bit bias from
// the parameter RAMs and hands them to the conv MAC as a single bundle.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for a start request
// FETCH | stepping weight addresses base..base+8, capturing taps as data lands
// DRAIN | bias address presented; last weight re-captured, then bias captured
// HOLD  | bundle valid, held stable until params_ready
module conv_param_fetch #(
    parameter int NUM_FILTERS = 4,
    parameter int KERNEL_TAPS = 9
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [2:0]  filter_idx,
    output logic [5:0]  w_rd_addr,
    input  logic [7:0]  w_rd_data,
    output logic [3:0]  b_rd_addr,
    input  logic [31:0] b_rd_data,
    output logic        busy,
    output logic        params_valid,
    input  logic        params_ready,
    output logic [71:0] weights,
    output logic [31:0] bias,
    output logic [2:0]  filter_out,
    output logic        err
);

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, HOLD} state_t;

    localparam logic [3:0] NF       = 4'(NUM_FILTERS);
    localparam logic [5:0] TAPS     = 6'(KERNEL_TAPS);
    localparam logic [3:0] LAST_TAP = 4'(KERNEL_TAPS - 1);

    state_t     state, state_nxt;
    logic [3:0] tap;
    logic       drain_ph;
    logic       xfer, legal, open_win, accept, reject;
    logic [5:0] base;

    assign xfer     = params_valid && params_ready;
    assign legal    = {1'b0, filter_idx} < NF;
    // a new request is only considered when idle or in the cycle the bundle leaves
    assign open_win = (state == IDLE) || ((state == HOLD) && xfer);
    assign accept   = open_win && start && legal;
    assign reject   = open_win && start && !legal;
    assign base     = {3'b000, filter_idx} * TAPS;

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (accept) state_nxt = FETCH;
            FETCH: if (tap == LAST_TAP) state_nxt = DRAIN;
            DRAIN: if (drain_ph) state_nxt = HOLD;
            HOLD:  if (xfer) state_nxt = accept ? FETCH : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // addresses, capture registers and status outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_rd_addr    <= '0;
            b_rd_addr    <= '0;
            busy         <= 1'b0;
            params_valid <= 1'b0;
            weights      <= '0;
            bias         <= '0;
            filter_out   <= '0;
            err          <= 1'b0;
            tap          <= '0;
            drain_ph     <= 1'b0;
        end else begin
            err <= reject;
            case (state)
                FETCH: begin
                    // the address presented last edge has its data on the bus now
                    weights[tap*8 +: 8] <= w_rd_data;
                    if (tap != LAST_TAP) begin
                        tap       <= tap + 4'd1;
                        w_rd_addr <= w_rd_addr + 6'd1;
                    end else begin
                        b_rd_addr <= {1'b0, filter_out};
                        drain_ph  <= 1'b0;
                    end
                end
                DRAIN: begin
                    // weight address is still on the last tap, so re-capturing is harmless
                    weights[LAST_TAP*8 +: 8] <= w_rd_data;
                    if (drain_ph) begin
                        bias         <= b_rd_data;
                        params_valid <= 1'b1;
                    end else begin
                        drain_ph <= 1'b1;
                    end
                end
                HOLD: begin
                    if (xfer) begin
                        params_valid <= 1'b0;
                        if (!accept) busy <= 1'b0;
                    end
                end
                default: ;
            endcase
            if (accept) begin
                filter_out <= filter_idx;
                busy       <= 1'b1;
                w_rd_addr  <= base;
                tap        <= '0;
            end
        end
    end

endmodule

// File: tb/tb_conv_param_fetch.sv
// Directed bench for conv_param_fetch with behavioural parameter RAMs.
module tb_conv_param_fetch;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  filter_idx = '0;
    logic [5:0]  w_rd_addr;
    logic [7:0]  w_rd_data;
    logic [3:0]  b_rd_addr;
    logic [31:0] b_rd_data;
    logic        busy;
    logic        params_valid;
    logic        params_ready = 1'b0;
    logic [71:0] weights;
    logic [31:0] bias;
    logic [2:0]  filter_out;
    logic        err;

    logic [7:0]  wmem [0:63];
    logic [31:0] bmem [0:15];

    int errors = 0;
    int checks = 0;

    conv_param_fetch dut (
        .clk(clk), .rst_n(rst_n), .start(start), .filter_idx(filter_idx),
        .w_rd_addr(w_rd_addr), .w_rd_data(w_rd_data),
        .b_rd_addr(b_rd_addr), .b_rd_data(b_rd_data),
        .busy(busy), .params_valid(params_valid), .params_ready(params_ready),
        .weights(weights), .bias(bias), .filter_out(filter_out), .err(err)
    );

    always #5 clk = ~clk;

    // RAM output register is the DUT's address register: data follows the address
    assign w_rd_data = wmem[w_rd_addr];
    assign b_rd_data = bmem[b_rd_addr];

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [2:0] idx);
        start = 1'b1;
        filter_idx = idx;
        tick();
        start = 1'b0;
    endtask

    // counts edges after the start edge until params_valid; bounded
    task automatic wait_valid(output int n, output bit busy_dropped);
        n = 0;
        busy_dropped = 1'b0;
        while (!params_valid && n < 20) begin
            tick();
            n++;
            if (!busy) busy_dropped = 1'b1;
        end
    endtask

    function automatic logic [71:0] exp_w(input int b);
        logic [71:0] w;
        for (int k = 0; k < 9; k++) w[8*k +: 8] = wmem[b + k];
        return w;
    endfunction

    task automatic release_bundle();
        params_ready = 1'b1;
        tick();
        params_ready = 1'b0;
        chk("valid_drop", params_valid, 0);
        chk("busy_drop", busy, 0);
    endtask

    int          n;
    bit          dropped;
    bit          err_seen;
    logic [71:0] w_snap;
    logic [71:0] w_exp;

    initial begin
        for (int i = 0; i < 64; i++) wmem[i] = (i < 36) ? 8'(i + 1) : 8'h00;
        for (int f = 0; f < 16; f++) bmem[f] = 32'h100 + f;

        #12;
        chk("reset_outputs", {w_rd_addr, b_rd_addr, busy, params_valid, weights, bias, filter_out, err}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // filter 2: address walk and latency
        do_start(3'd2);
        chk("f2_busy", busy, 1);
        chk("f2_addr_e0", w_rd_addr, 18);
        for (int k = 1; k <= 8; k++) begin
            tick();
            chk("f2_addr_walk", w_rd_addr, 18 + k);
            chk("f2_not_valid", params_valid, 0);
        end
        tick();
        chk("f2_baddr", b_rd_addr, 2);
        chk("f2_e9_not_valid", params_valid, 0);
        tick();
        chk("f2_e10_not_valid", params_valid, 0);
        tick();
        chk("f2_e11_valid", params_valid, 1);
        w_exp = '0;
        for (int k = 0; k < 9; k++) w_exp[8*k +: 8] = 8'(19 + k);
        chk("f2_weights", weights, w_exp);
        chk("f2_bias", bias, 32'h102);
        chk("f2_filter", filter_out, 2);

        // hold stability with ready low
        for (int c = 0; c < 5; c++) begin
            tick();
            chk("hold_valid", params_valid, 1);
            chk("hold_weights", weights, w_exp);
            chk("hold_bias", bias, 32'h102);
        end
        release_bundle();

        // back-to-back: filter 0 then filter 3 on the transfer edge
        do_start(3'd0);
        wait_valid(n, dropped);
        chk("f0_latency", n, 11);
        chk("f0_weights", weights, exp_w(0));
        chk("f0_bias", bias, 32'h100);
        params_ready = 1'b1;
        start = 1'b1;
        filter_idx = 3'd3;
        tick();
        start = 1'b0;
        params_ready = 1'b0;
        chk("b2b_valid_drop", params_valid, 0);
        chk("b2b_busy", busy, 1);
        chk("b2b_addr", w_rd_addr, 27);
        wait_valid(n, dropped);
        chk("f3_latency", n, 11);
        chk("f3_busy_never_dropped", dropped, 0);
        w_exp = '0;
        for (int k = 0; k < 9; k++) w_exp[8*k +: 8] = 8'(28 + k);
        chk("f3_weights", weights, w_exp);
        chk("f3_bias", bias, 32'h103);
        chk("f3_filter", filter_out, 3);
        release_bundle();

        // illegal index
        do_start(3'd5);
        chk("bad_err", err, 1);
        chk("bad_busy", busy, 0);
        chk("bad_waddr", w_rd_addr, 35);
        chk("bad_baddr", b_rd_addr, 3);
        tick();
        chk("bad_err_pulse", err, 0);

        // start pulse during FETCH is ignored
        do_start(3'd2);
        tick();
        tick();
        start = 1'b1;
        filter_idx = 3'd0;
        tick();
        start = 1'b0;
        err_seen = err;
        n = 3;
        while (!params_valid && n < 20) begin
            tick();
            n++;
            if (err) err_seen = 1'b1;
        end
        chk("ign_latency", n, 11);
        chk("ign_no_err", err_seen, 0);
        chk("ign_filter", filter_out, 2);
        chk("ign_weights", weights, exp_w(18));
        chk("ign_bias", bias, 32'h102);
        release_bundle();

        // sign patterns pass through unmodified
        wmem[9] = 8'h80;
        wmem[17] = 8'h7F;
        bmem[1] = 32'hFFFF_FF85;
        do_start(3'd1);
        wait_valid(n, dropped);
        chk("sgn_latency", n, 11);
        w_snap = weights;
        chk("sgn_tap0", w_snap[7:0], 8'h80);
        chk("sgn_tap8", w_snap[71:64], 8'h7F);
        chk("sgn_weights", weights, {8'h7F, 8'd17, 8'd16, 8'd15, 8'd14, 8'd13, 8'd12, 8'd11, 8'h80});
        chk("sgn_bias", bias, 32'hFFFF_FF85);
        release_bundle();

        // async reset mid-fetch
        do_start(3'd3);
        for (int k = 0; k < 5; k++) tick();
        rst_n = 1'b0;
        #1;
        chk("rst_mid_outputs", {w_rd_addr, b_rd_addr, busy, params_valid, weights, bias, filter_out, err}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("rst_idle_valid", params_valid, 0);
        do_start(3'd3);
        wait_valid(n, dropped);
        chk("post_rst_latency", n, 11);
        chk("post_rst_weights", weights, exp_w(27));
        chk("post_rst_bias", bias, 32'h103);
        chk("post_rst_filter", filter_out, 3);
        release_bundle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
